// File: rtl/hit_life_manager_if.sv
// Bus bundle for hit_life_manager: frame/hit/restart requests in, life/score/status out.
// The slave modport is the manager; the master modport is whatever drives the game events.
interface hit_life_manager_if;
  logic        startOfFrame;
  logic        SingleHitPulse_player;
  logic        SingleHitPulse_enemies;
  logic        restart;
  logic [2:0]  lives;
  logic [11:0] score;
  logic        player_freeze;
  logic        player_visible;
  logic        game_over;

  modport master (
    output startOfFrame, SingleHitPulse_player, SingleHitPulse_enemies, restart,
    input  lives, score, player_freeze, player_visible, game_over
  );

  modport slave (
    input  startOfFrame, SingleHitPulse_player, SingleHitPulse_enemies, restart,
    output lives, score, player_freeze, player_visible, game_over
  );
endinterface

// File: rtl/hit_life_manager.sv
// Player life / score manager: PLAY -> DYING -> INVULN -> PLAY, or GAME_OVER when lives run out.
// Optional macro HIT_LIFE_BLINK_EN makes the player blink (counter bit 2) while invulnerable.
module hit_life_manager #(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned DEATH_FRAMES  = 30,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input logic               clk,
  input logic               resetN,
  hit_life_manager_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [2:0]  LIVES_INIT  = 3'(INIT_LIVES);
  localparam logic [7:0]  DEATH_LOAD  = 8'(DEATH_FRAMES);
  localparam logic [7:0]  INVULN_LOAD = 8'(INVULN_FRAMES);
  localparam logic [11:0] SCORE_MAX   = 12'hFFF;

  state_e      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [11:0] score_q, score_d;
  logic [7:0]  counter_q, counter_d;
  logic        freeze_q, freeze_d;
  logic        visible_q, visible_d;
  logic        over_q, over_d;

  // NOTE: every value this block writes gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    counter_d = counter_q;

    if (bus.SingleHitPulse_enemies && (state_q != ST_GAME_OVER) && (score_q != SCORE_MAX)) begin
      score_d = score_q + 12'd1;
    end

    unique case (state_q)
      ST_PLAY: begin
        // A hit wins over a coincident frame tick: the fresh death count is not decremented.
        if (bus.SingleHitPulse_player) begin
          state_d   = ST_DYING;
          counter_d = DEATH_LOAD;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end
      end
      ST_DYING: begin
        if (bus.startOfFrame) begin
          if (counter_q == 8'd1) begin
            if (lives_q == 3'd0) begin
              state_d   = ST_GAME_OVER;
              counter_d = 8'd0;
            end else begin
              state_d   = ST_INVULN;
              counter_d = INVULN_LOAD;
            end
          end else begin
            counter_d = counter_q - 8'd1;
          end
        end
      end
      ST_INVULN: begin
        if (bus.startOfFrame) begin
          counter_d = counter_q - 8'd1;
          if (counter_q == 8'd1) state_d = ST_PLAY;
        end
      end
      ST_GAME_OVER: begin
        if (bus.restart) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_INIT;
          score_d   = 12'd0;
          counter_d = 8'd0;
        end
      end
      default: state_d = ST_PLAY;
    endcase

    // Status outputs are decoded from the next state so the registered copies line up with it.
    freeze_d = (state_d == ST_DYING) || (state_d == ST_GAME_OVER);
    over_d   = (state_d == ST_GAME_OVER);
`ifdef HIT_LIFE_BLINK_EN
    if (state_d == ST_INVULN) visible_d = counter_d[2];
    else                      visible_d = (state_d != ST_GAME_OVER);
`else
    visible_d = (state_d != ST_GAME_OVER);
`endif
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and wins over every input.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= ST_PLAY;
      lives_q   <= LIVES_INIT;
      score_q   <= 12'd0;
      counter_q <= 8'd0;
      freeze_q  <= 1'b0;
      visible_q <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      counter_q <= counter_d;
      freeze_q  <= freeze_d;
      visible_q <= visible_d;
      over_q    <= over_d;
    end
  end

  assign bus.lives          = lives_q;
  assign bus.score          = score_q;
  assign bus.player_freeze  = freeze_q;
  assign bus.player_visible = visible_q;
  assign bus.game_over      = over_q;

endmodule

// File: tb/tb_hit_life_manager.sv
// Self-checking bench for hit_life_manager: directed scenarios, then random events
// compared every cycle against a frame-countdown model of the game rules.
module tb_hit_life_manager;
  localparam int unsigned INIT_LIVES    = 3;
  localparam int unsigned DEATH_FRAMES  = 2;
  localparam int unsigned INVULN_FRAMES = 4;
  localparam int unsigned SCORE_MAX     = 4095;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  hit_life_manager_if bus ();

  hit_life_manager #(
    .INIT_LIVES   (INIT_LIVES),
    .DEATH_FRAMES (DEATH_FRAMES),
    .INVULN_FRAMES(INVULN_FRAMES)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the game is described by how many death / immunity frames remain.
  int unsigned m_lives, m_score, m_dead_left, m_immune_left;
  bit          m_over;

  task automatic model_step(input bit rn, input bit sof, input bit hit, input bit enm, input bit rs);
    if (!rn) begin
      m_lives = INIT_LIVES; m_score = 0; m_dead_left = 0; m_immune_left = 0; m_over = 0;
    end else if (m_over) begin
      if (rs) begin
        m_lives = INIT_LIVES; m_score = 0; m_over = 0;
      end
    end else begin
      if (enm && m_score < SCORE_MAX) m_score++;
      if (m_dead_left > 0) begin
        if (sof) begin
          m_dead_left--;
          if (m_dead_left == 0) begin
            if (m_lives == 0) m_over = 1;
            else              m_immune_left = INVULN_FRAMES;
          end
        end
      end else if (m_immune_left > 0) begin
        if (sof) m_immune_left--;
      end else if (hit) begin
        if (m_lives > 0) m_lives--;
        m_dead_left = DEATH_FRAMES;
      end
    end
  endtask

  function automatic int unsigned exp_visible();
    if (m_over) return 0;
`ifdef HIT_LIFE_BLINK_EN
    if (m_immune_left > 0) return (m_immune_left >> 2) & 1;
`endif
    return 1;
  endfunction

  task automatic compare_all();
    check("lives",  bus.lives,          m_lives);
    check("score",  bus.score,          m_score);
    check("freeze", bus.player_freeze,  (m_dead_left > 0 || m_over) ? 1 : 0);
    check("visible", bus.player_visible, exp_visible());
    check("game_over", bus.game_over,   m_over ? 1 : 0);
  endtask

  // One clock: drive inputs away from the edge, update the model at the edge, sample after it.
  task automatic cycle(input bit rn, input bit sof, input bit hit, input bit enm, input bit rs);
    resetN                     = rn;
    bus.startOfFrame           = sof;
    bus.SingleHitPulse_player  = hit;
    bus.SingleHitPulse_enemies = enm;
    bus.restart                = rs;
    @(posedge clk);
    model_step(rn, sof, hit, enm, rs);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic frame();
    idle(2);
    cycle(1, 1, 0, 0, 0);
  endtask

  task automatic lose_life();
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < int'(DEATH_FRAMES); i++) frame();
    if (!m_over) for (int i = 0; i < int'(INVULN_FRAMES); i++) frame();
  endtask

  initial begin
    // Reset, then one full death/immunity cycle.
    cycle(0, 1, 1, 1, 1);
    check("rst_lives", bus.lives, 3);
    check("rst_visible", bus.player_visible, 1);
    cycle(1, 0, 1, 0, 0);
    check("hit_lives", bus.lives, 2);
    check("hit_freeze", bus.player_freeze, 1);
    frame();
    frame();
    check("invuln_freeze", bus.player_freeze, 0);
    for (int i = 0; i < 4; i++) frame();

    // Hits while dying or immune are ignored, enemy hits still score.
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    check("dying_hit_ignored", bus.lives, 1);
    frame(); frame();
    cycle(1, 0, 1, 1, 0);
    check("invuln_hit_ignored", bus.lives, 1);
    for (int i = 0; i < 4; i++) frame();
    lose_life();
    check("last_life", bus.lives, 0);
    check("game_over_set", bus.game_over, 1);
    cycle(1, 0, 0, 0, 1);
    check("restart_lives", bus.lives, 3);
    check("restart_score", bus.score, 0);
    check("restart_over", bus.game_over, 0);

    // Score saturation and enemy hits in GAME_OVER.
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4094; i++) cycle(1, 0, 0, 1, 0);
    check("score_preload", bus.score, 4094);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0);
    check("score_sat", bus.score, 4095);
    lose_life(); lose_life(); lose_life();
    cycle(1, 0, 0, 1, 0);
    check("score_game_over", bus.score, 4095);
    cycle(1, 0, 0, 0, 1);

    // Hit + enemy + frame tick together: death count starts at full length.
    cycle(1, 1, 1, 1, 0);
    check("combo_lives", bus.lives, 2);
    check("combo_score", bus.score, 1);
    frame();
    check("combo_still_dying", bus.player_freeze, 1);
    frame();
    check("combo_dying_done", bus.player_freeze, 0);
`ifdef HIT_LIFE_BLINK_EN
    check("blink_cnt4", bus.player_visible, 1);
`endif
    frame();
`ifdef HIT_LIFE_BLINK_EN
    check("blink_cnt3", bus.player_visible, 0);
`endif
    cycle(0, 1, 1, 1, 0);
    check("midreset_lives", bus.lives, 3);
    check("midreset_visible", bus.player_visible, 1);
    check("midreset_freeze", bus.player_freeze, 0);

    // Random traffic, occasional resets.
    for (int i = 0; i < 6000; i++) begin
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hit_life_manager.md
HIT_LIFE_MANAGER -- requirements
Module: hit_life_manager

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded at reset and restart (legal 1..7).
REQ-002 Parameter DEATH_FRAMES, default 30, frames spent frozen after a player hit (legal 1..255).
REQ-003 Parameter INVULN_FRAMES, default 60, frames of hit immunity after the death phase (legal 1..255).
REQ-004 Port clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port resetN  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 Port startOfFrame  input  1  one-cycle pulse at the start of each video frame.
REQ-007 Port SingleHitPulse_player  input  1  one-cycle pulse, at most one per frame, for a player hit.
REQ-008 Port SingleHitPulse_enemies  input  1  one-cycle pulse, at most one per frame, for an enemy hit.
REQ-009 Port restart  input  1  level request to start a new game, honoured only in GAME_OVER.
REQ-010 Port lives  output  3  remaining lives, unsigned.
REQ-011 Port score  output  12  enemy-hit count, unsigned, saturating.
REQ-012 Port player_freeze  output  1  high while player movement must be held.
REQ-013 Port player_visible  output  1  gate for the player drawing request.
REQ-014 Port game_over  output  1  high in GAME_OVER.

Function
REQ-015 FSM states SHALL be PLAY, DYING, INVULN and GAME_OVER, encoded in a registered state vector.
REQ-016 PLAY + SingleHitPulse_player -> DYING on the next edge; lives decremented by 1 on the same edge; frame counter loaded with DEATH_FRAMES.
REQ-017 DYING: counter decrements by 1 on each startOfFrame; on a startOfFrame with counter==1 -> GAME_OVER if lives==0, otherwise -> INVULN with counter loaded with INVULN_FRAMES.
REQ-018 INVULN: counter decrements by 1 on each startOfFrame; on a startOfFrame with counter==1 -> PLAY.
REQ-019 SingleHitPulse_player SHALL be ignored in DYING, INVULN and GAME_OVER; lives never underflow below 0.
REQ-020 PLAY + SingleHitPulse_player + startOfFrame in the same cycle: the hit SHALL take effect; the new counter is not decremented in that cycle.
REQ-021 SingleHitPulse_enemies SHALL increment score by 1 in PLAY, DYING and INVULN, and SHALL be ignored in GAME_OVER; at 4095 score holds.
REQ-022 Player hit + enemy hit in the same cycle: both SHALL take effect.
REQ-023 GAME_OVER + restart -> PLAY on the next edge; lives=INIT_LIVES, score=0, counter=0.
REQ-024 player_freeze SHALL be 1 in DYING and GAME_OVER, else 0; game_over SHALL be 1 only in GAME_OVER.
REQ-025 All outputs SHALL be registered; state/output change latency from the triggering input is exactly one clock.

Reset
REQ-026 resetN==0 at a rising edge SHALL set state=PLAY, lives=INIT_LIVES, score=0, counter=0, player_freeze=0, player_visible=1, game_over=0.
REQ-027 Reset SHALL override every input in the same cycle, including mid-DYING or mid-INVULN; no partial count survives.

Configuration
REQ-028 Macro HIT_LIFE_BLINK_EN defined: player_visible = counter bit 2 during INVULN (blinks every 4 frames), 0 in GAME_OVER, 1 otherwise.
REQ-029 Macro HIT_LIFE_BLINK_EN undefined: player_visible = 0 in GAME_OVER, 1 otherwise; no blink logic is synthesized.

Verification (INIT_LIVES=3, DEATH_FRAMES=2, INVULN_FRAMES=4)
REQ-030 Reset, then a player hit in PLAY -> next cycle lives=2, player_freeze=1; after 2 startOfFrame pulses -> INVULN, freeze=0; after 4 more -> PLAY.
REQ-031 Player hit pulses during DYING and INVULN -> lives stays 2; a hit after return to PLAY -> lives=1.
REQ-032 Three hits, each separated by full recovery -> lives=0, then after 2 frames game_over=1; restart=1 -> next cycle lives=3, score=0, game_over=0.
REQ-033 Preload score to 4094 via 4094 enemy pulses, then 3 more -> score=4095; enemy pulse in GAME_OVER -> score unchanged.
REQ-034 Player hit, enemy hit and startOfFrame in the same PLAY cycle -> lives decremented, score+1, counter=2 (not 1).
REQ-035 resetN=0 mid-INVULN with counter=3 -> next edge state=PLAY, lives=3, player_visible=1; with HIT_LIFE_BLINK_EN, INVULN counter=4 -> player_visible=1; counter=3 -> 0.
